// File: rtl/fp_mul_arbiter.sv
// fp_mul_arbiter: round-robin sequencer sharing one non-pipelined FP multiplier among N_REQ requesters.
// Define FP_MUL_ARB_TIMEOUT_EN to add a WAIT timeout with a quiet-NaN response and a sticky err output.
module fp_mul_arbiter #(
    parameter int N_REQ   = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [32*N_REQ-1:0] req_a,
    input  logic [32*N_REQ-1:0] req_b,
    input  logic [N_REQ-1:0]    req_stb,
    output logic [N_REQ-1:0]    req_ack,
    output logic [31:0]         rsp_z,
    output logic [N_REQ-1:0]    rsp_stb,
    input  logic [N_REQ-1:0]    rsp_ack,
    output logic [31:0]         mul_a,
    output logic [31:0]         mul_b,
    output logic                mul_in_stb,
    input  logic                mul_in_ack,
    input  logic [31:0]         mul_z,
    input  logic                mul_z_stb,
    output logic                mul_z_ack,
`ifdef FP_MUL_ARB_TIMEOUT_EN
    output logic                err,
`endif
    output logic                busy,
    output logic [ID_W-1:0]     grant_id
);
    typedef enum logic [2:0] {IDLE, ACCEPT, ISSUE, WAIT, RETURN} state_t;
    state_t          state;
    logic [ID_W-1:0] rr_ptr, off, pick, next_ptr;
    logic [ID_W:0]   sum;
    logic [N_REQ-1:0] rot;
`ifdef FP_MUL_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;
    logic          stale;
`endif

    // Rotate requests so bit 0 is rr_ptr, take the lowest set bit, rotate back.
    always_comb begin
        rot = N_REQ'({req_stb, req_stb} >> rr_ptr);
        off = '0;
        for (int k = N_REQ - 1; k >= 0; k--)
            if (rot[k]) off = ID_W'(k);
        sum = {1'b0, rr_ptr} + {1'b0, off};
        pick = sum >= (ID_W + 1)'(N_REQ) ? ID_W'(sum - (ID_W + 1)'(N_REQ)) : ID_W'(sum);
        next_ptr = grant_id == ID_W'(N_REQ - 1) ? '0 : grant_id + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            grant_id   <= '0;
            req_ack    <= '0;
            rsp_stb    <= '0;
            rsp_z      <= '0;
            mul_a      <= '0;
            mul_b      <= '0;
            mul_in_stb <= 1'b0;
            mul_z_ack  <= 1'b0;
            busy       <= 1'b0;
`ifdef FP_MUL_ARB_TIMEOUT_EN
            cnt        <= '0;
            stale      <= 1'b0;
            err        <= 1'b0;
`endif
        end else begin
`ifdef FP_MUL_ARB_TIMEOUT_EN
            // Absorb the result of a timed-out operation whenever it finally shows up.
            if (stale && state != WAIT) begin
                mul_z_ack <= !(mul_z_stb && mul_z_ack);
                if (mul_z_stb && mul_z_ack) stale <= 1'b0;
            end
`endif
            case (state)
                IDLE: if (|req_stb) begin
                    grant_id <= pick;
                    req_ack  <= N_REQ'(1) << pick;
                    busy     <= 1'b1;
                    state    <= ACCEPT;
                end
                ACCEPT: begin
                    req_ack <= '0;
                    if (req_stb[grant_id]) begin
                        mul_a      <= 32'(req_a >> {grant_id, 5'd0});
                        mul_b      <= 32'(req_b >> {grant_id, 5'd0});
                        mul_in_stb <= 1'b1;
                        state      <= ISSUE;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                ISSUE: if (mul_in_ack) begin
                    mul_in_stb <= 1'b0;
                    mul_z_ack  <= 1'b1;
`ifdef FP_MUL_ARB_TIMEOUT_EN
                    cnt        <= '0;
`endif
                    state      <= WAIT;
                end
                WAIT: if (mul_z_stb) begin
                    rsp_z     <= mul_z;
                    mul_z_ack <= 1'b0;
                    rsp_stb   <= N_REQ'(1) << grant_id;
                    state     <= RETURN;
                end
`ifdef FP_MUL_ARB_TIMEOUT_EN
                else if (cnt == CW'(TIMEOUT - 1)) begin
                    rsp_z     <= 32'hFFC0_0000;
                    mul_z_ack <= 1'b0;
                    rsp_stb   <= N_REQ'(1) << grant_id;
                    stale     <= 1'b1;
                    err       <= 1'b1;
                    state     <= RETURN;
                end else cnt <= cnt + 1'b1;
`endif
                RETURN: if (rsp_ack[grant_id]) begin
                    rsp_stb <= '0;
                    rr_ptr  <= next_ptr;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
